// File: rtl/even_parity_pkg.sv
// Shared definitions for the even-parity serial transmitter and its matching checker.
package even_parity_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_e;

   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

   // Counter width able to hold n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/even_parity_gen.sv
// XOR reduction of a W-bit word; shared by the transmitter and the receive-side checker.
module even_parity_gen #(
   parameter int W = 3
) (
   input  logic [W-1:0] data_i,
   output logic         parity_o
);

   assign parity_o = ^data_i;

endmodule

// File: rtl/even_parity_serial_tx.sv
// Serial frame transmitter: start, DATA_W bits LSB first, parity, stop; BIT_CYCLES clocks per bit.
// Define EVEN_PARITY_TX_ODD_EN to send the inverted (odd) parity bit.
module even_parity_serial_tx
   import even_parity_pkg::*;
#(
   parameter int DATA_W     = 3,
   parameter int BIT_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              tx,
   output logic              busy,
   output logic              frame_done
);

   localparam int CNT_W = cnt_width(BIT_CYCLES);
   localparam int IDX_W = cnt_width(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

`ifdef EVEN_PARITY_TX_ODD_EN
   localparam logic PAR_INV = 1'b1;
`else
   localparam logic PAR_INV = 1'b0;
`endif

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              par_q, par_d;
   logic              tx_q, tx_d;
   logic              par_w;
   logic              bit_end;
   logic [DATA_W-1:0] shr_w;

   even_parity_gen #(.W(DATA_W)) u_par (
      .data_i   (in),
      .parity_o (par_w)
   );

   assign bit_end = (cnt_q == CNT_LAST);
   assign shr_w   = data_q >> 1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         par_q   <= 1'b0;
         tx_q    <= IDLE_LEVEL;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
      end
   end

   // tx_d is the level of the bit the next state will present, so tx is a pure flop output.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      data_d  = data_q;
      par_d   = par_q;
      tx_d    = tx_q;
      unique case (state_q)
         IDLE: begin
            tx_d = IDLE_LEVEL;
            if (in_valid) begin
               state_d = START;
               data_d  = in;
               par_d   = par_w ^ PAR_INV;
               cnt_d   = '0;
               idx_d   = '0;
               tx_d    = START_BIT;
            end
         end
         START: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (bit_end) begin
               cnt_d   = '0;
               state_d = DATA;
               tx_d    = data_q[0];
            end
         end
         DATA: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (bit_end) begin
               cnt_d = '0;
               if (idx_q == IDX_LAST) begin
                  state_d = PARITY;
                  tx_d    = par_q;
               end else begin
                  idx_d  = idx_q + IDX_W'(1);
                  data_d = shr_w;
                  tx_d   = shr_w[0];
               end
            end
         end
         PARITY: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (bit_end) begin
               cnt_d   = '0;
               state_d = STOP;
               tx_d    = STOP_BIT;
            end
         end
         STOP: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (bit_end) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = IDLE;
               tx_d    = IDLE_LEVEL;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            tx_d    = IDLE_LEVEL;
         end
      endcase
   end

   assign in_ready   = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign frame_done = (state_q == STOP) && bit_end;
   assign tx         = tx_q;

endmodule

// File: tb/tb_even_parity_serial_tx.sv
// Bench for even_parity_serial_tx: directed frame table, reset abort, back-to-back and random frames.
module tb_even_parity_serial_tx;

   localparam int DW = 3;
   localparam int BC = 4;
   localparam int NB = DW + 3;
   localparam int FL = NB * BC;

`ifdef EVEN_PARITY_TX_ODD_EN
   localparam bit ODD = 1'b1;
`else
   localparam bit ODD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] din = '0;
   logic          in_valid = 1'b0;
   logic          in_ready, tx, busy, frame_done;

   int tests = 0;
   int failed = 0;

   even_parity_serial_tx #(.DATA_W(DW), .BIT_CYCLES(BC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in         (din),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .tx         (tx),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   // Line trace expected for payload d: each frame bit repeated BC times, first sample = index 0.
   function automatic logic [FL-1:0] model_line(input logic [DW-1:0] d);
      logic bits[$];
      logic [FL-1:0] l;
      int ones = 0;
      bits.push_back(1'b0);
      for (int i = 0; i < DW; i++) begin
         bits.push_back(d[i]);
         ones += int'(d[i]);
      end
      bits.push_back(logic'(ones % 2) ^ ODD);
      bits.push_back(1'b1);
      for (int k = 0; k < FL; k++) l[k] = bits[k / BC];
      return l;
   endfunction

   // Receiver: mid-bit sampling, deserialize, parity and framing check.
   task automatic rx_decode(input logic [FL-1:0] l, output logic [DW-1:0] d, output bit perr,
                            output bit ferr);
      logic [NB-1:0] b;
      int ones = 0;
      for (int i = 0; i < NB; i++) b[i] = l[i * BC + BC / 2];
      for (int i = 1; i <= DW + 1; i++) ones += int'(b[i]);
      d    = b[DW:1];
      perr = ((ones % 2) == 1) ^ ODD;
      ferr = (b[0] !== 1'b0) || (b[NB-1] !== 1'b1);
   endtask

   // At a negedge: wait for in_ready (bounded), then present d with in_valid.
   task automatic offer(input logic [DW-1:0] d, output int waited);
      waited = 0;
      while (in_ready !== 1'b1 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (in_ready !== 1'b1) chk("ready_timeout", {63'd0, in_ready}, 64'd1);
      din      = d;
      in_valid = 1'b1;
   endtask

   // Transfer edge, then FL samples of the line; in is scrambled every cycle throughout.
   task automatic capture(input bit hold_valid, output logic [FL-1:0] l, output int done_cnt,
                          output int done_pos, output bit hs_ok, output bit idle_ok);
      done_cnt = 0;
      done_pos = -1;
      hs_ok    = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= FL; k++) begin
         @(negedge clk);
         din = DW'($urandom);
         if (!hold_valid) in_valid = 1'b0;
         l[k-1] = tx;
         if (frame_done === 1'b1) begin
            done_cnt++;
            done_pos = k;
         end
         if (busy !== 1'b1 || in_ready !== 1'b0) hs_ok = 1'b0;
      end
      @(negedge clk);
      idle_ok = (in_ready === 1'b1) && (busy === 1'b0) && (tx === 1'b1) && (frame_done === 1'b0);
   endtask

   typedef struct {
      logic [DW-1:0] d;
      logic [NB-1:0] bits;
   } vec_t;

   initial begin
      vec_t          vecs[4];
      logic [FL-1:0] l, el;
      logic [DW-1:0] rd;
      bit            perr, ferr, hs_ok, idle_ok;
      int            dcnt, dpos, w;

      vecs[0] = '{d: 3'b101, bits: 6'b101010};
      vecs[1] = '{d: 3'b001, bits: 6'b110010};
      vecs[2] = '{d: 3'b000, bits: 6'b100000};
      vecs[3] = '{d: 3'b011, bits: 6'b100110};

      // reset state
      #12;
      chk("rst_tx", {63'd0, tx}, 64'd1);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, frame_done}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", {63'd0, in_ready}, 64'd1);

      // directed table
      for (int i = 0; i < 4; i++) begin
         el = '0;
         for (int k = 0; k < FL; k++) el[k] = vecs[i].bits[k / BC] ^ ((k / BC == NB - 2) ? ODD : 1'b0);
         offer(vecs[i].d, w);
         capture(1'b0, l, dcnt, dpos, hs_ok, idle_ok);
         chk($sformatf("tbl%0d_line", i), 64'(l), 64'(el));
         chk($sformatf("tbl%0d_done_cnt", i), 64'(dcnt), 64'd1);
         chk($sformatf("tbl%0d_done_pos", i), 64'(dpos), 64'(FL));
         chk($sformatf("tbl%0d_hs", i), {63'd0, hs_ok}, 64'd1);
         chk($sformatf("tbl%0d_idle", i), {63'd0, idle_ok}, 64'd1);
      end

      // reset during DATA of 3'b110, then a clean 3'b011 frame
      offer(3'b110, w);
      @(posedge clk);
      for (int k = 1; k <= BC + 2; k++) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      chk("abort_pre_busy", {63'd0, busy}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_tx", {63'd0, tx}, 64'd1);
      chk("abort_busy", {63'd0, busy}, 64'd0);
      chk("abort_done", {63'd0, frame_done}, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      dcnt = 0;
      for (int k = 0; k < FL; k++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) dcnt++;
      end
      chk("abort_no_resume", 64'(dcnt), 64'd0);
      offer(3'b011, w);
      capture(1'b0, l, dcnt, dpos, hs_ok, idle_ok);
      chk("post_abort_line", 64'(l), 64'(model_line(3'b011)));
      chk("post_abort_done", 64'(dpos), 64'(FL));

      // all payloads back-to-back with in_valid held and in churning
      offer(3'd0, w);
      for (int v = 0; v < 8; v++) begin
         capture(1'b1, l, dcnt, dpos, hs_ok, idle_ok);
         rx_decode(l, rd, perr, ferr);
         chk($sformatf("b2b%0d_data", v), 64'(rd), 64'(v));
         chk($sformatf("b2b%0d_perr", v), {63'd0, perr}, 64'd0);
         chk($sformatf("b2b%0d_ferr", v), {63'd0, ferr}, 64'd0);
         chk($sformatf("b2b%0d_hs", v), {63'd0, hs_ok}, 64'd1);
         chk($sformatf("b2b%0d_idle", v), {63'd0, idle_ok}, 64'd1);
         if (v < 7) begin
            offer(DW'(v + 1), w);
            chk($sformatf("b2b%0d_gap", v), 64'(w), 64'd0);
         end
      end
      in_valid = 1'b0;

      // random payloads with random idle gaps
      for (int n = 0; n < 20; n++) begin
         logic [DW-1:0] d;
         d = DW'($urandom);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         offer(d, w);
         capture(1'b0, l, dcnt, dpos, hs_ok, idle_ok);
         chk($sformatf("rnd%0d_line d=%0d", n, d), 64'(l), 64'(model_line(d)));
         chk($sformatf("rnd%0d_done", n), 64'(dpos), 64'(FL));
         chk($sformatf("rnd%0d_idle", n), {63'd0, idle_ok}, 64'd1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
